// File: rtl/conv_mac.sv
// conv_mac: multiply-accumulate stage behind the nested-loop address generator.
//
// Each accepted term drives its weight/input addresses straight to two
// synchronous-read memories. The returned operands are multiplied as signed
// values, and the products are summed. When the term flagged as last reaches
// the accumulator, the completed group sum is emitted for one cycle.
//
// Parameters:
//   AW   - address width for weight and input memories
//   DW   - signed operand width
//   ACCW - accumulator / result width (must be at least 2*DW)
//
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   in_valid, in_last     - term strobe and end-of-group flag
//   in_wa, in_ia          - weight / input address of the term
//   w_addr, w_en, w_rdata - weight memory port (1-cycle read latency)
//   i_addr, i_en, i_rdata - input memory port (1-cycle read latency)
//   out_valid, out_data   - single-cycle result pulse and held group sum
//   busy                  - a term is still in flight in the pipeline
module conv_mac #(
    parameter int AW   = 32,
    parameter int DW   = 8,
    parameter int ACCW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_last,
    input  logic [AW-1:0]   in_wa,
    input  logic [AW-1:0]   in_ia,
    output logic [AW-1:0]   w_addr,
    output logic            w_en,
    input  logic [DW-1:0]   w_rdata,
    output logic [AW-1:0]   i_addr,
    output logic            i_en,
    input  logic [DW-1:0]   i_rdata,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);

    // Stage 1: term is in the memory read cycle
    logic v1_d, v1_q;
    logic l1_d, l1_q;
    // Stage 2: product of the returned operands
    logic v2_d, v2_q;
    logic l2_d, l2_q;
    logic signed [2*DW-1:0] prod_d, prod_q;
    // Stage 3: accumulator and result
    logic [ACCW-1:0] acc_d, acc_q;
    logic            first_d, first_q;
    logic            out_valid_d, out_valid_q;
    logic [ACCW-1:0] out_data_d, out_data_q;

    logic [ACCW-1:0] prod_ext_s;
    logic [ACCW-1:0] acc_sum_s;

    // Memories see the generator's addresses without delay so data returns in stage 1.
    assign w_addr = in_wa;
    assign i_addr = in_ia;
    assign w_en   = in_valid;
    assign i_en   = in_valid;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = v1_q | v2_q;

    // Next-state computation for all pipeline stages
    always_comb begin
        v1_d   = in_valid;
        l1_d   = in_valid & in_last;
        v2_d   = v1_q;
        l2_d   = l1_q;
        prod_d = $signed(w_rdata) * $signed(i_rdata);

        // Size cast of a signed value sign-extends the product into the accumulator width.
        prod_ext_s = ACCW'(prod_q);
        // A group's first term overwrites the old sum instead of adding to it.
        acc_sum_s  = (first_q ? {ACCW{1'b0}} : acc_q) + prod_ext_s;

        acc_d       = acc_q;
        first_d     = first_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;

        if (v2_q) begin
            acc_d = acc_sum_s;
            if (l2_q) begin
                out_data_d  = acc_sum_s;
                out_valid_d = 1'b1;
                first_d     = 1'b1;
            end else begin
                first_d = 1'b0;
            end
        end else begin
            // Bubble: sum and group position are held.
            acc_d   = acc_q;
            first_d = first_q;
        end
    end

    // Pipeline, accumulator and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            prod_q      <= {(2*DW){1'b0}};
            acc_q       <= {ACCW{1'b0}};
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACCW{1'b0}};
        end else begin
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            v2_q        <= v2_d;
            l2_q        <= l2_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac: a 24-bit and a 16-bit accumulator instance
// share stimulus; each has its own synchronous-read memory model.
module tb_conv_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_wa = 32'd0;
    logic [31:0] in_ia = 32'd0;

    logic [31:0] w_addr, i_addr, w_addr16, i_addr16;
    logic        w_en, i_en, w_en16, i_en16;
    logic [7:0]  w_rdata = 8'd0, i_rdata = 8'd0, w_rdata16 = 8'd0, i_rdata16 = 8'd0;
    logic        out_valid, out_valid16, busy, busy16;
    logic [23:0] out_data;
    logic [15:0] out_data16;

    logic [7:0] wmem [256];
    logic [7:0] imem [256];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int gaps [27];

    int          rq_cyc [$];
    logic [31:0] rq_dat [$];
    int          rq16_cyc [$];
    logic [31:0] rq16_dat [$];

    conv_mac #(.AW(32), .DW(8), .ACCW(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_wa(in_wa), .in_ia(in_ia),
        .w_addr(w_addr), .w_en(w_en), .w_rdata(w_rdata),
        .i_addr(i_addr), .i_en(i_en), .i_rdata(i_rdata),
        .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    conv_mac #(.AW(32), .DW(8), .ACCW(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_wa(in_wa), .in_ia(in_ia),
        .w_addr(w_addr16), .w_en(w_en16), .w_rdata(w_rdata16),
        .i_addr(i_addr16), .i_en(i_en16), .i_rdata(i_rdata16),
        .out_valid(out_valid16), .out_data(out_data16), .busy(busy16)
    );

    always #5 clk = ~clk;

    // cycle counter: value during a cycle is the number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read memory models, one read port per DUT memory interface
    always @(posedge clk) begin
        if (w_en)   w_rdata   <= wmem[w_addr[7:0]];
        if (i_en)   i_rdata   <= imem[i_addr[7:0]];
        if (w_en16) w_rdata16 <= wmem[w_addr16[7:0]];
        if (i_en16) i_rdata16 <= imem[i_addr16[7:0]];
    end

    // result monitor, sampled 1 time unit after the rising edge
    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            rq_cyc.push_back(cyc);
            rq_dat.push_back({8'd0, out_data});
        end
        if (out_valid16) begin
            rq16_cyc.push_back(cyc);
            rq16_dat.push_back({16'd0, out_data16});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_term(input int wa, input int ia, input logic last,
                              input bit chk_addr, output int t);
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = last;
        in_wa    = 32'(wa);
        in_ia    = 32'(ia);
        t        = cyc;
        if (chk_addr) begin
            #1;
            check_val("w_addr", w_addr, 32'(wa));
            check_val("i_addr", i_addr, 32'(ia));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // 27-term 3x3x3 group; gaps[k] idle cycles follow term k
    task automatic group27(input int woff, input bit chk_addr, output int t_last);
        int t;
        t_last = 0;
        for (int c = 0; c < 3; c++)
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 3; x++) begin
                    int k;
                    k = c * 9 + y * 3 + x;
                    drive_term(woff + k, c * 100 + y * 10 + x, (k == 26) ? 1'b1 : 1'b0, chk_addr, t);
                    if (k == 26) t_last = t;
                    for (int g = 0; g < gaps[k]; g++) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                        in_last  = 1'b0;
                        if (g == 0) check_val("busy_in_gap", {31'd0, busy}, 32'd1);
                        if (g == 2) check_val("busy_drained", {31'd0, busy}, 32'd0);
                    end
                end
    endtask

    // wait (bounded) for a result pulse, then check its cycle and value
    task automatic expect_pulse(input string tag, input bit sel16,
                                input int exp_cyc, input logic [31:0] exp_data);
        int n;
        int sz;
        int gc;
        logic [31:0] gd;
        n  = 0;
        sz = sel16 ? rq16_cyc.size() : rq_cyc.size();
        while (sz == 0 && n < 10) begin
            @(negedge clk);
            n++;
            sz = sel16 ? rq16_cyc.size() : rq_cyc.size();
        end
        check_val({tag, "_present"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            if (sel16) begin
                gc = rq16_cyc.pop_front();
                gd = rq16_dat.pop_front();
            end else begin
                gc = rq_cyc.pop_front();
                gd = rq_dat.pop_front();
            end
            check_val({tag, "_cycle"}, 32'(gc), 32'(exp_cyc));
            check_val({tag, "_data"}, gd, exp_data);
        end
    endtask

    task automatic expect_quiet(input string tag);
        idle(5);
        check_val(tag, 32'(rq_cyc.size()), 32'd0);
    endtask

    initial begin
        int tl, tl2;
        int t0, t1, t2;

        for (int a = 0; a < 256; a++) begin
            wmem[a] = 8'd0;
            imem[a] = 8'd2;
        end
        for (int a = 0; a < 27; a++) begin
            wmem[a]      = 8'd1;
            wmem[32 + a] = 8'd3;
        end
        wmem[100] = 8'hFD;  // -3
        wmem[101] = 8'h80;  // -128
        wmem[102] = 8'h7F;  // 127
        imem[240] = 8'd5;
        imem[241] = 8'h80;  // -128
        imem[242] = 8'hFF;  // -1
        imem[243] = 8'h7F;  // 127
        for (int k = 0; k < 27; k++) gaps[k] = 0;

        // reset state
        #12;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_data", {8'd0, out_data}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // plain 27-term group, address sequence checked
        group27(0, 1'b1, tl);
        idle(1);
        expect_pulse("g1", 1'b0, tl + 3, 32'd54);
        expect_quiet("g1_extra");

        // same group with idle stretches of 1, 3 and 2 cycles
        gaps[5] = 1; gaps[12] = 3; gaps[20] = 2;
        group27(0, 1'b0, tl);
        idle(1);
        expect_pulse("g2", 1'b0, tl + 3, 32'd54);
        expect_quiet("g2_extra");
        gaps[5] = 0; gaps[12] = 0; gaps[20] = 0;

        // two groups back to back, weights 1 then 3
        group27(0, 1'b0, tl);
        group27(32, 1'b0, tl2);
        idle(1);
        expect_pulse("b2b_a", 1'b0, tl + 3, 32'd54);
        expect_pulse("b2b_b", 1'b0, tl2 + 3, 32'd162);
        check_val("b2b_spacing", 32'(tl2 - tl), 32'd27);
        expect_quiet("b2b_extra");

        // signed single-term groups on consecutive cycles
        drive_term(100, 240, 1'b1, 1'b0, t0);
        drive_term(101, 241, 1'b1, 1'b0, t1);
        drive_term(102, 242, 1'b1, 1'b0, t2);
        idle(1);
        expect_pulse("sgn_m15", 1'b0, t0 + 3, 32'h00FFFFF1);
        expect_pulse("sgn_16384", 1'b0, t1 + 3, 32'h00004000);
        expect_pulse("sgn_m127", 1'b0, t2 + 3, 32'h00FFFF81);
        expect_quiet("sgn_extra");

        // wrap-around on the 16-bit accumulator
        rq16_cyc.delete();
        rq16_dat.delete();
        drive_term(102, 243, 1'b0, 1'b0, t0);
        drive_term(102, 243, 1'b0, 1'b0, t1);
        drive_term(102, 243, 1'b1, 1'b0, t2);
        idle(1);
        expect_pulse("ovf16", 1'b1, t2 + 3, 32'h0000BD03);
        expect_pulse("ovf24", 1'b0, t2 + 3, 32'h0000BD03);
        expect_quiet("ovf_extra");

        // reset mid-group discards the partial sum
        for (int k = 0; k < 10; k++) drive_term(k, k, 1'b0, 1'b0, t0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_wa    = 32'd77;
        in_ia    = 32'd5;
        #1;
        check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_out_data", {8'd0, out_data}, 32'd0);
        check_val("mid_rst_out_data16", {16'd0, out_data16}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_w_en", {31'd0, w_en}, 32'd1);
        check_val("mid_rst_i_en", {31'd0, i_en}, 32'd1);
        check_val("mid_rst_w_addr", w_addr, 32'd77);
        check_val("mid_rst_i_addr", i_addr, 32'd5);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        expect_quiet("aborted_group_quiet");
        group27(0, 1'b0, tl);
        idle(1);
        expect_pulse("after_rst", 1'b0, tl + 3, 32'd54);
        expect_quiet("after_rst_extra");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
